// File: rtl/sig_dump.sv
// sig_dump: memory-mapped signature dumper.
// Walks [BEGIN, END) through a dedicated RAM read port and streams each word
// as four bytes, LSB first, on a valid/ready byte stream.
// Optional feature macro: SIG_DUMP_CRC_EN (CRC-32 over streamed signature
// bytes, readable at 0xC, appended as a 4-byte trailer).
module sig_dump #(
   parameter int AW = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          reg_sel,
   input  logic          reg_wr,
   input  logic [3:0]    reg_addr,
   input  logic [31:0]   reg_wdata,
   output logic [31:0]   reg_rdata,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_rvalid,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic          irq
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_FETCH,
      S_WAIT,
      S_SEND,
`ifdef SIG_DUMP_CRC_EN
      S_TRAIL,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t        state, state_d;
   logic [AW-1:0] begin_ptr, end_ptr, ptr;
   logic [AW-1:0] ptr_next;
   logic [31:0]   word;
   logic [1:0]    idx;
   logic          ie, done, err;
   logic          busy;
   logic          wr_acc, rd_acc, ctrl_wr, start, clr;
   logic          accept;
   logic          unused_wdata;

`ifdef SIG_DUMP_CRC_EN
   logic [31:0]   crc;

   // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'b0, b};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction
`endif

   assign unused_wdata = ^reg_wdata[31:AW];

   assign wr_acc   = reg_sel && reg_wr;
   assign rd_acc   = reg_sel && !reg_wr;
   assign ctrl_wr  = wr_acc && (reg_addr == 4'h8);
   assign busy     = !(state == S_IDLE || state == S_DONE || state == S_ERR);
   assign start    = ctrl_wr && reg_wdata[0] && !busy;
   assign clr      = ctrl_wr && reg_wdata[2];
   assign accept   = out_valid && out_ready;
   assign ptr_next = ptr + AW'(4);
   assign irq      = done && ie;

   // State register; reset returns to IDLE immediately, dropping the strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // Next-state decode and stream/RAM strobes.
   always_comb begin
      state_d   = state;
      mem_req   = 1'b0;
      mem_addr  = '0;
      out_valid = 1'b0;
      out_data  = '0;
      unique case (state)
         S_IDLE: begin
            if (start) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (end_ptr <= begin_ptr || begin_ptr[1:0] != 2'b00 || end_ptr[1:0] != 2'b00)
               state_d = S_ERR;
            else
               state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = ptr;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) state_d = S_SEND;
         end
         S_SEND: begin
            out_valid = 1'b1;
            out_data  = word[{idx, 3'b000} +: 8];
            if (out_ready && idx == 2'd3) begin
               if (ptr_next == end_ptr)
`ifdef SIG_DUMP_CRC_EN
                  state_d = S_TRAIL;
`else
                  state_d = S_DONE;
`endif
               else
                  state_d = S_FETCH;
            end
         end
`ifdef SIG_DUMP_CRC_EN
         S_TRAIL: begin
            out_valid = 1'b1;
            out_data  = ~crc[{idx, 3'b000} +: 8];
            if (out_ready && idx == 2'd3) state_d = S_DONE;
         end
`endif
         S_DONE, S_ERR: begin
            state_d = start ? S_CHECK : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers, walk pointer, captured word, byte index and CRC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         begin_ptr <= '0;
         end_ptr   <= '0;
         ptr       <= '0;
         word      <= '0;
         idx       <= '0;
         ie        <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef SIG_DUMP_CRC_EN
         crc       <= '1;
`endif
      end else begin
         if (wr_acc && !busy && reg_addr == 4'h0) begin_ptr <= reg_wdata[AW-1:0];
         if (wr_acc && !busy && reg_addr == 4'h4) end_ptr   <= reg_wdata[AW-1:0];
         if (ctrl_wr) ie <= reg_wdata[1];
         if (clr) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (start) begin
            done <= 1'b0;
`ifdef SIG_DUMP_CRC_EN
            crc  <= '1;
`endif
         end
         if (state_d == S_DONE) done <= 1'b1;
         if (state_d == S_ERR)  err  <= 1'b1;
         if (state == S_CHECK) ptr <= begin_ptr;
         if (state == S_WAIT && mem_rvalid) begin
            word <= mem_rdata;
            idx  <= '0;
         end
         if (accept) begin
            idx <= idx + 2'd1;
            if (state == S_SEND) begin
`ifdef SIG_DUMP_CRC_EN
               crc <= crc_byte(crc, out_data);
`endif
               if (idx == 2'd3) ptr <= ptr_next;
            end
         end
      end
   end

   // Registered read data, one cycle after a read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_rdata <= '0;
      end else if (rd_acc) begin
         unique case (reg_addr)
            4'h0:    reg_rdata <= 32'(begin_ptr);
            4'h4:    reg_rdata <= 32'(end_ptr);
            4'h8:    reg_rdata <= {28'b0, err, done, busy, ie};
`ifdef SIG_DUMP_CRC_EN
            4'hC:    reg_rdata <= ~crc;
`else
            4'hC:    reg_rdata <= '0;
`endif
            default: reg_rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sig_dump.sv
// tb_sig_dump: table-driven register checks plus directed dump sequences.
module tb_sig_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_sel, reg_wr;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        irq;

   int total = 0;
   int bad = 0;

   sig_dump #(.AW(22)) dut (
      .clk(clk), .rst(rst),
      .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // RAM model with programmable read latency
   logic [31:0] ram [int unsigned];
   int          lat = 1;
   int          pend = 0;
   logic [21:0] paddr;

   always @(negedge clk) begin
      if (rst) begin
         pend = 0;
         mem_rvalid = 1'b0;
      end else begin
         mem_rvalid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = ram[32'(paddr)];
            end
         end
         if (mem_req) begin
            paddr = mem_addr;
            pend  = lat;
         end
      end
   end

   // Sink ready pattern: 0 = always ready, 1 = ready one cycle in three
   int rdy_mode = 0;
   int cyc = 0;
   always @(negedge clk) begin
      cyc++;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
   end

   // Byte sink and stall stability monitor
   logic [7:0] got[$];
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = '0;
   int         stall_viol = 0;
   int         stall_cnt = 0;
   always @(posedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && (!out_valid || out_data !== stall_data)) stall_viol++;
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         if (stall_prev) stall_cnt++;
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   logic [7:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'b0, q[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic exp_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   task automatic exp_trailer();
`ifdef SIG_DUMP_CRC_EN
      logic [31:0] c;
      c = crc_of(exp_q);
      exp_word(c);
`endif
   endtask

   task automatic cmp_stream(input string nm);
      chk({nm, " len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s byte%0d", nm, i), {24'b0, got[i]}, {24'b0, exp_q[i]});
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
      reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_sel = 1'b0; reg_wr = 1'b0;
   endtask

   task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
      reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = a;
      @(negedge clk);
      reg_sel = 1'b0;
      d = reg_rdata;
   endtask

   task automatic wait_done(output logic [31:0] st);
      st = '0;
      for (int i = 0; i < 500; i++) begin
         reg_read(4'h8, st);
         if (st[2] || st[3]) break;
      end
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[14];
   logic [31:0] rd, st;
   logic [31:0] sig_crc;

   initial begin
      tbl[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
      tbl[1]  = '{1'b0, 4'h4, 32'h0,        32'h0};
      tbl[2]  = '{1'b0, 4'h8, 32'h0,        32'h0};
      tbl[3]  = '{1'b0, 4'hC, 32'h0,        32'h0};
      tbl[4]  = '{1'b1, 4'h0, 32'hFFC00100, 32'h0};
      tbl[5]  = '{1'b0, 4'h0, 32'h0,        32'h00000100};
      tbl[6]  = '{1'b1, 4'h4, 32'h12345108, 32'h0};
      tbl[7]  = '{1'b0, 4'h4, 32'h0,        32'h00345108};
      tbl[8]  = '{1'b1, 4'h8, 32'h00000002, 32'h0};
      tbl[9]  = '{1'b0, 4'h8, 32'h0,        32'h00000001};
      tbl[10] = '{1'b1, 4'h8, 32'h00000000, 32'h0};
      tbl[11] = '{1'b0, 4'h8, 32'h0,        32'h00000000};
      tbl[12] = '{1'b1, 4'h8, 32'h00000004, 32'h0};
      tbl[13] = '{1'b0, 4'h8, 32'h0,        32'h00000000};

      ram[32'h100] = 32'h11223344;
      ram[32'h104] = 32'hAABBCCDD;
      ram[32'h300] = 32'h00333231;

      rst = 1'b1; reg_sel = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst mem_addr", 32'(mem_addr), 32'h0);
      chk("rst out_data", {24'b0, out_data}, 32'h0);
      chk("rst irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // register vectors
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].wdata);
         else begin
            reg_read(tbl[i].addr, rd);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
         end
      end

      // 1: two-word dump, sink always ready, ie on
      reg_write(4'h0, 32'h100);
      reg_write(4'h4, 32'h108);
      got.delete(); exp_q.delete();
      exp_word(32'h11223344); exp_word(32'hAABBCCDD); exp_trailer();
      reg_write(4'h8, 32'h3);
      reg_read(4'h8, rd);
      chk("t1 busy", rd, 32'h3);
      wait_done(st);
      chk("t1 status", st, 32'h5);
      chk("t1 irq", {31'b0, irq}, 32'h1);
      cmp_stream("t1");

      // 2: same dump with a stalling sink and longer RAM latency
      rdy_mode = 1; lat = 3; stall_viol = 0; stall_cnt = 0;
      got.delete();
      reg_write(4'h8, 32'h3);
      reg_read(4'h8, rd);
      chk("t2 done cleared", rd, 32'h3);
      wait_done(st);
      chk("t2 status", st, 32'h5);
      cmp_stream("t2");
      chk("t2 stable", stall_viol, 0);
      chk("t2 stalled", {31'b0, stall_cnt > 0}, 32'h1);
      rdy_mode = 0; lat = 1;
      @(negedge clk);

      // 3: empty range -> err within 3 cycles, no bytes
      reg_write(4'h0, 32'h200);
      reg_write(4'h4, 32'h200);
      got.delete();
      reg_write(4'h8, 32'h1);
      @(negedge clk);
      reg_read(4'h8, rd);
      chk("t3 err", rd, 32'h8);
      repeat (5) @(negedge clk);
      chk("t3 no bytes", got.size(), 0);
      chk("t3 irq", {31'b0, irq}, 32'h0);
      reg_write(4'h8, 32'h4);
      reg_read(4'h8, rd);
      chk("t3 clr", rd, 32'h0);

      // 4: misaligned BEGIN, then BEGIN/END writes during busy ignored
      reg_write(4'h0, 32'h102);
      reg_write(4'h4, 32'h108);
      got.delete();
      reg_write(4'h8, 32'h1);
      wait_done(st);
      chk("t4 misalign", st, 32'h8);
      chk("t4 no bytes", got.size(), 0);
      reg_write(4'h8, 32'h4);
      reg_write(4'h0, 32'h100);
      got.delete(); exp_q.delete();
      exp_word(32'h11223344); exp_word(32'hAABBCCDD); exp_trailer();
      reg_write(4'h8, 32'h1);
      reg_write(4'h0, 32'h104);
      reg_write(4'h4, 32'h10C);
      wait_done(st);
      chk("t4 status", st, 32'h4);
      cmp_stream("t4");
      reg_read(4'h0, rd);
      chk("t4 begin kept", rd, 32'h100);
      reg_read(4'h4, rd);
      chk("t4 end kept", rd, 32'h108);

      // 5: reset while byte 2 is on the stream
      got.delete();
      reg_write(4'h8, 32'h1);
      for (int i = 0; i < 200; i++) begin
         if (got.size() == 2 && out_valid) break;
         @(negedge clk);
      end
      chk("t5 reached byte2", {24'b0, out_data}, 32'h22);
      rst = 1'b1;
      #1;
      chk("t5 out_valid drop", {31'b0, out_valid}, 32'h0);
      chk("t5 mem_req drop", {31'b0, mem_req}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      reg_read(4'h8, rd);
      chk("t5 status", rd, 32'h0);
      reg_read(4'h0, rd);
      chk("t5 begin reset", rd, 32'h0);
      reg_write(4'h0, 32'h100);
      reg_write(4'h4, 32'h108);
      got.delete();
      reg_write(4'h8, 32'h1);
      wait_done(st);
      chk("t5 rerun status", st, 32'h4);
      cmp_stream("t5");

      // 6: single word "123\0", CRC register and trailer
      reg_write(4'h0, 32'h300);
      reg_write(4'h4, 32'h304);
      got.delete(); exp_q.delete();
      exp_word(32'h00333231);
      sig_crc = crc_of(exp_q);
      exp_trailer();
      reg_write(4'h8, 32'h3);
      wait_done(st);
      chk("t6 status", st, 32'h5);
      cmp_stream("t6");
      reg_read(4'hC, rd);
`ifdef SIG_DUMP_CRC_EN
      chk("t6 crc reg", rd, sig_crc);
`else
      chk("t6 crc reg", rd, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
